// File: rtl/cv32e40p_obi_mem_responder_if.sv
// cv32e40p_obi_mem_responder_if: OBI request/grant/response bundle between core port and memory responder
interface cv32e40p_obi_mem_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/cv32e40p_obi_mem_responder.sv
// cv32e40p_obi_mem_responder: byte-enabled word RAM answering OBI requests in order after a fixed latency
module cv32e40p_obi_mem_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int RESP_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  cv32e40p_obi_mem_responder_if.slave      bus,
  input  logic                             gnt_stall_i,
  output logic [3:0]                       outstanding_o
);
  localparam int AW = $clog2(MEM_WORDS);
  if (MEM_WORDS < 2 || (1 << AW) != MEM_WORDS) begin : g_bad_words
    $error("MEM_WORDS must be a power of two >= 2");
  end
  if (RESP_LATENCY < 1 || RESP_LATENCY > 8) begin : g_bad_lat
    $error("RESP_LATENCY must be 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_out
    $error("MAX_OUTSTANDING must be 1..8");
  end
  logic [31:0]             mem [MEM_WORDS];
  logic [RESP_LATENCY-1:0] pv;
  logic [31:0]             pd [RESP_LATENCY];
  logic [3:0]              cnt;
  logic [AW-1:0]           idx;
  logic                    unused_addr;
  // Byte offset and bits above the index are dropped, so high addresses alias low words
  assign idx           = bus.addr[AW+1:2];
  assign unused_addr   = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign bus.rvalid    = pv[RESP_LATENCY-1];
  assign bus.rdata     = pd[RESP_LATENCY-1];
  // A retiring response frees its slot in the same cycle, keeping full throughput
  assign bus.gnt       = bus.req && !gnt_stall_i && !rst_i
                         && (cnt < 4'(MAX_OUTSTANDING) || bus.rvalid);
  assign outstanding_o = cnt;
  // RAM write with per-byte enables; contents survive reset
  always_ff @(posedge clk_i)
    if (bus.gnt && bus.we)
      for (int n = 0; n < 4; n++)
        if (bus.be[n]) mem[idx][8*n +: 8] <= bus.wdata[8*n +: 8];
  // Response shift register and outstanding counter; invalid stages carry zero data
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pv  <= '0;
      cnt <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= bus.gnt;
      pd[0] <= (bus.gnt && !bus.we) ? mem[idx] : '0;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      cnt <= cnt + 4'(bus.gnt) - 4'(bus.rvalid);
    end
endmodule
